dma_multi: RTL and testbench
============================

// Module: dma_multi
// PURPOSE
//  Parametrised multi-channel DMA engine for BrainForge8; successor to the single-channel DMA.
//  NCH independent channels share one 8-bit bus master port. Each grant moves one byte,
//  then the engine re-arbitrates round-robin. Per-channel source and destination strides.
//  Per-channel done, error and busy flags feed the interrupt controller.
// PARAMETERS
//  NCH  4  number of channels (2..8)
//  LW   8  length counter width in bits (8..16)
//  CW   2  channel select width, $clog2(NCH)
// PORTS
//  CLK    in    1      system clock
//  RST    in    1      reset, asynchronous, active-low
//  RUN    in    1      1-cycle load strobe for channel CH
//  CH     in    CW     channel addressed by RUN
//  SRC    in    16     start source address
//  DST    in    16     start destination address
//  LEN    in    LW     byte count; 0 = cancel channel CH
//  SINC   in    8      source stride, unsigned
//  DINC   in    8      destination stride, unsigned
//  FILL   in    1      fill mode request; see CONFIGURATION
//  D      inout 8      data bus; driven only in WRITE, else 8'bz
//  A      out   16     address bus
//  RW     out   1      1 = read, 0 = write
//  BR     out   1      bus request
//  BA     in    1      bus acknowledge
//  DONE   out   NCH    1-cycle pulse per channel on last byte written
//  ERR    out   NCH    1-cycle pulse per channel on RUN to an active channel
//  BUSY   out   NCH    channel active (loaded, bytes remaining)
// BEHAVIOUR
//  Reset: A=0, RW=1, BR=0, D=z, DONE=0, ERR=0, BUSY=0, state=ARB, rr pointer=NCH-1.
//  Per-channel registers: src, dst, len (LW), sinc, dinc, fill, active.
//  RUN with LEN!=0 to an inactive channel: load all fields, active=1 next cycle.
//  RUN with LEN!=0 to an active channel: ignored; ERR[CH] pulses next cycle.
//  RUN with LEN==0: channel cancelled, active=0, no DONE. If CH owns the bus in READ/WRITE,
//   the current byte completes first; its counters are then discarded.
//  States: ARB, REQ, READ, WRITE.
//   ARB: BR=0. Grant the first active channel searching from (last_grant+1) mod NCH.
//    None active: stay in ARB.
//   REQ: BR=1. On BA: A<=src, RW<=1 -> READ; in fill mode skip the read: A<=dst, RW<=0 -> WRITE.
//   READ: BR=1. BA high: latch D, A<=dst, RW<=0 -> WRITE. BA low: -> REQ, retry the read.
//   WRITE: BR=1, D=buffer. Hold until BA. On BA: src+=sinc, dst+=dinc, len-=1, RW<=1 -> ARB.
//    If len was 1: DONE[g] pulses and active cleared on the same edge.
//  Addresses wrap modulo 2^16; strides are zero-extended.
//  Throughput with BA held high: 4 cycles/byte (ARB, REQ, READ, WRITE); fill mode 3.
//  First BR: RUN sampled at edge n -> ARB grants at n+1 -> BR high after edge n+1.
//  RUN in the same cycle as the channel's final write: active is still 1, so ERR pulses.
//  A RUN to a different channel during a transfer is legal and never disturbs the owner.
//  RST low mid-transfer: all channels cleared immediately; no DONE.
// CONFIGURATION
//  DMA_FILL_EN defined: a channel loaded with FILL=1 writes the low byte of SRC to every
//   destination address (no bus read); src does not advance.
//  DMA_FILL_EN undefined: FILL ignored; fill logic not synthesised; every channel copies.
// TESTING
//  ch0 SRC=1000 DST=2000 LEN=3 SINC=1 DINC=1, BA tied 1
//   -> reads 1000..1002, writes 2000..2002; DONE[0] 12 cycles after grant.
//  ch0 and ch2 both LEN=2, BA=1 -> grants alternate 0,2,0,2; DONE[0] precedes DONE[2] by 4 cycles.
//  ch1 active, RUN CH=1 LEN=5 -> ERR[1] 1-cycle pulse; ch1 fields unchanged.
//  ch1 mid-copy, RUN CH=1 LEN=0 -> current byte written, BUSY[1] falls, DONE[1] stays 0.
//  SRC=FFFF DST=FFFE DINC=2 LEN=2 -> reads FFFF then 0000; writes FFFE then 0000 (wrap).
//  DMA_FILL_EN: FILL=1 SRC=00A5 DST=3000 LEN=4 -> A5 written to 3000..3003, RW never 1 in WRITE.

Source files
------------

// File: rtl/dma_multi_if.sv
// dma_multi_if: shared 8-bit bus master handshake (address, direction, request, acknowledge).
// The data bus D stays a plain inout on the DMA so tri-state resolution happens on a net.
interface dma_multi_if;
  logic [15:0] A;
  logic        RW;
  logic        BR;
  logic        BA;

  modport master (output A, output RW, output BR, input BA);
  modport slave  (input A, input RW, input BR, output BA);
endinterface

// File: rtl/dma_multi.sv
// dma_multi: NCH-channel byte DMA sharing one 8-bit bus master, round-robin re-arbitration per byte.
// Optional fill mode (constant byte to every destination) is compiled in with `define DMA_FILL_EN.
module dma_multi #(
  parameter int NCH = 4,
  parameter int LW  = 8,
  parameter int CW  = $clog2(NCH)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           RUN,
  input  logic [CW-1:0]  CH,
  input  logic [15:0]    SRC,
  input  logic [15:0]    DST,
  input  logic [LW-1:0]  LEN,
  input  logic [7:0]     SINC,
  input  logic [7:0]     DINC,
  input  logic           FILL,
  inout  wire  [7:0]     D,
  dma_multi_if.master    bus,
  output logic [NCH-1:0] DONE,
  output logic [NCH-1:0] ERR,
  output logic [NCH-1:0] BUSY
);

  typedef enum logic [1:0] {ARB, REQ, READ, WRITE} state_t;

  state_t          r_state, w_next;
  logic [15:0]     r_src  [NCH];
  logic [15:0]     r_dst  [NCH];
  logic [LW-1:0]   r_len  [NCH];
  logic [7:0]      r_sinc [NCH];
  logic [7:0]      r_dinc [NCH];
  logic [NCH-1:0]  r_active;
  logic [CW-1:0]   r_g;
  logic [CW-1:0]   w_win;
  logic            w_found;
  logic [7:0]      r_buf;
  logic            r_abort;
  logic            w_fill_g;
  logic            w_doe;
  logic            w_ch_ok;
  logic            w_load;
  logic            w_cancel;
  logic            w_cancel_g;

`ifdef DMA_FILL_EN
  logic [NCH-1:0]  r_fill;
  assign w_fill_g = r_fill[r_g];
`else
  logic            w_unused_fill;
  assign w_unused_fill = FILL;
  assign w_fill_g      = 1'b0;
`endif

  assign w_ch_ok    = 32'(CH) < 32'(NCH);
  assign w_cancel   = RUN && w_ch_ok && (LEN == '0);
  assign w_load     = RUN && w_ch_ok && (LEN != '0);
  assign w_cancel_g = w_cancel && (CH == r_g);
  assign BUSY       = r_active;
  assign D          = w_doe ? r_buf : 'z;

  // Round-robin search for the first active channel after the last grant.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_g;
    for (int unsigned i = 1; i <= NCH; i++) begin
      int unsigned k;
      k = (32'(r_g) + i) % NCH;
      if (!w_found && r_active[CW'(k)]) begin
        w_found = 1'b1;
        w_win   = CW'(k);
      end
    end
  end

  // Bus-cycle sequencing; a cancelled owner drops back to ARB from REQ.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB:     if (w_found) w_next = REQ;
      REQ:     if (!r_active[r_g]) w_next = ARB;
               else if (bus.BA)    w_next = w_fill_g ? WRITE : READ;
      READ:    w_next = bus.BA ? WRITE : REQ;
      WRITE:   if (bus.BA) w_next = ARB;
      default: w_next = ARB;
    endcase
  end

  // Bus request and data drive follow the state directly.
  always_comb begin
    bus.BR = (r_state != ARB);
    w_doe  = (r_state == WRITE);
  end

  // State register.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= ARB;
    else      r_state <= w_next;
  end

  // Datapath: bus address/direction, channel counters, load/cancel, status pulses.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      bus.A    <= '0;
      bus.RW   <= 1'b1;
      r_buf    <= '0;
      r_abort  <= 1'b0;
      r_g      <= CW'(NCH - 1);
      r_active <= '0;
      DONE     <= '0;
      ERR      <= '0;
`ifdef DMA_FILL_EN
      r_fill   <= '0;
`endif
      for (int unsigned i = 0; i < NCH; i++) begin
        r_src[CW'(i)]  <= '0;
        r_dst[CW'(i)]  <= '0;
        r_len[CW'(i)]  <= '0;
        r_sinc[CW'(i)] <= '0;
        r_dinc[CW'(i)] <= '0;
      end
    end else begin
      DONE <= '0;
      ERR  <= '0;
      case (r_state)
        ARB: begin
          r_abort <= 1'b0;
          if (w_found) r_g <= w_win;
        end
        REQ: if (bus.BA && r_active[r_g]) begin
          if (w_fill_g) begin
            bus.A  <= r_dst[r_g];
            bus.RW <= 1'b0;
            r_buf  <= r_src[r_g][7:0];
          end else begin
            bus.A  <= r_src[r_g];
            bus.RW <= 1'b1;
          end
        end
        READ: if (bus.BA) begin
          r_buf  <= D;
          bus.A  <= r_dst[r_g];
          bus.RW <= 1'b0;
        end
        WRITE: if (bus.BA) begin
          bus.RW  <= 1'b1;
          r_abort <= 1'b0;
          // A cancel seen earlier in this byte lets the write finish but drops its counter update.
          if (!r_abort) begin
            if (!w_fill_g) r_src[r_g] <= r_src[r_g] + {8'h00, r_sinc[r_g]};
            r_dst[r_g] <= r_dst[r_g] + {8'h00, r_dinc[r_g]};
            r_len[r_g] <= r_len[r_g] - LW'(1);
            if (r_len[r_g] == LW'(1)) begin
              r_active[r_g] <= 1'b0;
              DONE[r_g]     <= !w_cancel_g;
            end
          end
        end
        default: ;
      endcase
      // Host commands come last so a reload after a cancel overrides any in-flight update.
      if (w_cancel) begin
        r_active[CH] <= 1'b0;
        if ((CH == r_g) && (r_state != ARB) && !((r_state == WRITE) && bus.BA))
          r_abort <= 1'b1;
      end else if (w_load) begin
        if (r_active[CH]) begin
          ERR[CH] <= 1'b1;
        end else begin
          r_src[CH]    <= SRC;
          r_dst[CH]    <= DST;
          r_len[CH]    <= LEN;
          r_sinc[CH]   <= SINC;
          r_dinc[CH]   <= DINC;
          r_active[CH] <= 1'b1;
`ifdef DMA_FILL_EN
          r_fill[CH]   <= FILL;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_multi.sv
// tb_dma_multi: directed plus randomized checks of dma_multi against a transaction-level model.
// The model lists, per load, every expected (destination, byte) write; the bus slave returns
// memfn(address) on reads. Fill-mode checks are included when DMA_FILL_EN is defined.
module tb_dma_multi;

  logic        CLK = 1'b0;
  logic        RST;
  logic        RUN;
  logic [1:0]  CH;
  logic [15:0] SRC, DST;
  logic [7:0]  LEN, SINC, DINC;
  logic        FILL;
  wire  [7:0]  D;
  logic [3:0]  DONE, ERR, BUSY;

  dma_multi_if bus ();

  dma_multi #(.NCH(4), .LW(8)) dut (
    .CLK(CLK), .RST(RST), .RUN(RUN), .CH(CH), .SRC(SRC), .DST(DST), .LEN(LEN),
    .SINC(SINC), .DINC(DINC), .FILL(FILL), .D(D), .bus(bus),
    .DONE(DONE), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] memfn(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8];
    return a[7:0] + hi + hi + hi + 8'h11;
  endfunction

  // Bus slave: supplies read data whenever the master is in read direction.
  assign D = (bus.RW == 1'b1) ? memfn(bus.A) : 8'hzz;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  ch;
    logic [15:0] a;
    logic [7:0]  d;
    logic        last;
  } wr_t;

  wr_t        expq[$];
  wr_t        nq[$];
  int         order_ch[$];
  logic [15:0] order_a[$];
  logic [3:0] pend_done = '0;
  int         done_cyc[4];
  logic       ba_rand = 1'b0;

  bit         sb_found;
  int         sb_idx;
  logic [3:0] sb_seen;

  // Slave acknowledge: tied high or randomly stalled.
  always @(posedge CLK) begin
    #1;
    bus.BA = ba_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Scoreboard: each completing write must be the next expected byte of some channel.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      for (int c = 0; c < 4; c++) if (DONE[c]) done_cyc[c] = cyc;
      if (pend_done != 0 || DONE != 0) chk("done", 32'(DONE), 32'(pend_done));
      pend_done = '0;
      if (bus.BR && bus.BA && !bus.RW) begin
        sb_found = 1'b0;
        sb_idx   = 0;
        sb_seen  = '0;
        for (int i = 0; i < expq.size(); i++) begin
          if (!sb_found && !sb_seen[expq[i].ch]) begin
            if (expq[i].a == bus.A && expq[i].d == D) begin
              sb_found = 1'b1;
              sb_idx   = i;
            end
            sb_seen[expq[i].ch] = 1'b1;
          end
        end
        checks++;
        assert (sb_found === 1'b1) else begin
          errors++;
          $error("FAIL write: observed A=%h D=%h expected a queued channel byte", bus.A, D);
        end
        if (sb_found) begin
          order_ch.push_back(int'(expq[sb_idx].ch));
          order_a.push_back(bus.A);
          if (expq[sb_idx].last) pend_done[expq[sb_idx].ch] = 1'b1;
          expq.delete(sb_idx);
        end
      end
    end
  end

  function automatic int model_cnt(input int ch);
    int n = 0;
    foreach (expq[i]) if (int'(expq[i].ch) == ch) n++;
    return n;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // One-cycle RUN strobe; the model queues the expected writes when a load is expected.
  task automatic load(input int ch, input logic [15:0] src, input logic [15:0] dst,
                      input logic [7:0] len, input logic [7:0] sinc, input logic [7:0] dinc,
                      input logic fill, input bit expect_load);
    wr_t e;
    CH = 2'(ch); SRC = src; DST = dst; LEN = len; SINC = sinc; DINC = dinc; FILL = fill;
    RUN = 1'b1;
    if (expect_load) begin
      for (int k = 0; k < int'(len); k++) begin
        e.ch = 2'(ch);
        e.a  = dst + 16'(k * int'(dinc));
`ifdef DMA_FILL_EN
        e.d  = fill ? src[7:0] : memfn(src + 16'(k * int'(sinc)));
`else
        e.d  = memfn(src + 16'(k * int'(sinc)));
`endif
        e.last = (k == int'(len) - 1);
        expq.push_back(e);
      end
    end
    @(posedge CLK);
    #1;
    RUN = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((expq.size() != 0 || BUSY != 0) && n < maxc) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("idle_timeout", 32'(n < maxc), 32'd1);
    tick(2);
  endtask

  task automatic clear_log();
    order_ch.delete();
    order_a.delete();
  endtask

  initial begin
    bit hit;
    RST = 1'b1; RUN = 1'b0; CH = '0; SRC = '0; DST = '0; LEN = '0;
    SINC = '0; DINC = '0; FILL = 1'b0; bus.BA = 1'b1;
    #3 RST = 1'b0;
    @(negedge CLK);
    chk("rst_A", 32'(bus.A), 32'h0);
    chk("rst_RW", 32'(bus.RW), 32'd1);
    chk("rst_BR", 32'(bus.BR), 32'd0);
    chk("rst_DONE", 32'(DONE), 32'd0);
    chk("rst_ERR", 32'(ERR), 32'd0);
    chk("rst_BUSY", 32'(BUSY), 32'd0);
    tick(1);
    RST = 1'b1;
    tick(1);

    // Basic copy and first-BR / DONE latency.
    clear_log();
    load(0, 16'h1000, 16'h2000, 8'd3, 8'd1, 8'd1, 1'b0, 1'b1);
    chk("first_busy", 32'(BUSY), 32'h1);
    chk("first_br_low", 32'(bus.BR), 32'd0);
    tick(1);
    chk("first_br_high", 32'(bus.BR), 32'd1);
    tick(10);
    chk("done0_early", 32'(DONE[0]), 32'd0);
    tick(1);
    chk("done0_at_12", 32'(DONE[0]), 32'd1);
    tick(1);
    chk("done0_pulse_end", 32'(DONE[0]), 32'd0);
    chk("busy_after_done", 32'(BUSY), 32'd0);
    wait_idle(50);
    chk("copy_nwrites", 32'(order_a.size()), 32'd3);

    // Round-robin alternation between ch0 and ch2.
    clear_log();
    load(0, 16'h1100, 16'h2100, 8'd2, 8'd1, 8'd1, 1'b0, 1'b1);
    load(2, 16'h1200, 16'h2200, 8'd2, 8'd1, 8'd1, 1'b0, 1'b1);
    wait_idle(80);
    chk("rr_nwrites", 32'(order_ch.size()), 32'd4);
    if (order_ch.size() == 4) begin
      chk("rr_g0", 32'(order_ch[0]), 32'd0);
      chk("rr_g1", 32'(order_ch[1]), 32'd2);
      chk("rr_g2", 32'(order_ch[2]), 32'd0);
      chk("rr_g3", 32'(order_ch[3]), 32'd2);
    end
    chk("rr_done_gap", 32'(done_cyc[2] - done_cyc[0]), 32'd4);

    // RUN to an active channel: ERR pulse, original transfer unaffected.
    clear_log();
    load(1, 16'h4000, 16'h5000, 8'd4, 8'd1, 8'd1, 1'b0, 1'b1);
    tick(3);
    load(1, 16'h7777, 16'h7777, 8'd5, 8'd3, 8'd3, 1'b0, 1'b0);
    chk("err_pulse", 32'(ERR), 32'h2);
    tick(1);
    chk("err_pulse_end", 32'(ERR), 32'h0);
    wait_idle(80);
    chk("err_nwrites", 32'(order_a.size()), 32'd4);

    // Cancel mid-copy during the second byte's read: that byte completes, no DONE.
    clear_log();
    load(1, 16'h6000, 16'h6100, 8'd6, 8'd1, 8'd1, 1'b0, 1'b1);
    hit = 1'b0;
    for (int t = 0; t < 60 && !hit; t++) begin
      @(negedge CLK);
      if (bus.BR && bus.RW && bus.A == 16'h6001) hit = 1'b1;
    end
    chk("cancel_read_seen", 32'(hit), 32'd1);
    CH = 2'd1; LEN = 8'd0; RUN = 1'b1;
    begin
      bit kept = 1'b0;
      nq.delete();
      foreach (expq[i]) begin
        if (expq[i].ch != 2'd1 || !kept) begin
          nq.push_back(expq[i]);
          if (expq[i].ch == 2'd1) kept = 1'b1;
        end
      end
      expq = nq;
    end
    @(posedge CLK);
    #1;
    RUN = 1'b0;
    wait_idle(40);
    chk("cancel_nwrites", 32'(order_a.size()), 32'd2);
    if (order_a.size() == 2) chk("cancel_last_addr", 32'(order_a[1]), 32'h6101);
    chk("cancel_busy", 32'(BUSY), 32'd0);

    // Address wrap with stride 2 on the destination.
    clear_log();
    load(3, 16'hFFFF, 16'hFFFE, 8'd2, 8'd1, 8'd2, 1'b0, 1'b1);
    wait_idle(40);
    chk("wrap_nwrites", 32'(order_a.size()), 32'd2);
    if (order_a.size() == 2) begin
      chk("wrap_w0", 32'(order_a[0]), 32'hFFFE);
      chk("wrap_w1", 32'(order_a[1]), 32'h0000);
    end

`ifdef DMA_FILL_EN
    // Fill mode: constant byte, no reads.
    clear_log();
    load(0, 16'h00A5, 16'h3000, 8'd4, 8'd1, 8'd1, 1'b1, 1'b1);
    wait_idle(40);
    chk("fill_nwrites", 32'(order_a.size()), 32'd4);
`endif

    // Randomized channels, strides and acknowledge stalls.
    ba_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 4; c++) begin
        load(c, 16'($urandom), 16'($urandom), 8'($urandom_range(1, 5)),
             8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        tick($urandom_range(0, 3));
      end
      if (model_cnt(0) >= 2) begin
        load(0, 16'h0, 16'h0, 8'd3, 8'd1, 8'd1, 1'b0, 1'b0);
        chk("rand_err", 32'(ERR), 32'h1);
      end
      wait_idle(600);
    end
    ba_rand = 1'b0;

    // Reset in the middle of a transfer clears everything at once.
    load(2, 16'h8000, 16'h9000, 8'd8, 8'd1, 8'd1, 1'b0, 1'b1);
    tick(6);
    RST = 1'b0;
    #1;
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_br", 32'(bus.BR), 32'd0);
    chk("midrst_A", 32'(bus.A), 32'h0);
    chk("midrst_RW", 32'(bus.RW), 32'd1);
    expq.delete();
    pend_done = '0;
    tick(2);
    RST = 1'b1;
    tick(3);
    chk("post_rst_done", 32'(DONE), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
